// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control/status bundle between the multi-cycle controller and the PC sequencer.
interface pc_sequencer_if #(
  parameter int WIDTH = 32,
  parameter int CPI   = 4
);
  localparam int PW = $clog2(CPI);
  logic             run;
  logic             halt;
  logic             stall;
  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_target;
  logic [WIDTH-1:0] pc_out;
  logic [PW-1:0]    phase;
  logic             last_phase;
  logic             instr_done;
  logic             running;
  logic             misalign_err;
  modport master (
    output run, halt, stall, redirect_valid, redirect_target,
    input  pc_out, phase, last_phase, instr_done, running, misalign_err
  );
  modport slave (
    input  run, halt, stall, redirect_valid, redirect_target,
    output pc_out, phase, last_phase, instr_done, running, misalign_err
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle program counter; advances once per CPI-clock window by increment or latched redirect.
module pc_sequencer #(
  parameter int               WIDTH        = 32,
  parameter int               CPI          = 4,
  parameter int               INC          = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               ALIGN_BITS   = 2
) (
  input logic            clk,
  input logic            rst_n,
  pc_sequencer_if.slave  bus
);
  localparam int               PW      = $clog2(CPI);
  localparam logic [PW-1:0]    LAST    = PW'(CPI - 1);
  localparam logic [WIDTH-1:0] LO_MASK = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);
  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
  state_t           state;
  logic [PW-1:0]    phase;
  logic [WIDTH-1:0] pc, tgt, rv_tgt, next_pc;
  logic             redir_pend, halt_pend, run_q, done, err, running;
  logic             in_run, take_rv, win_end, go_halt;
  always_comb begin
    in_run  = state == RUN;
    take_rv = in_run && bus.redirect_valid;
    rv_tgt  = bus.redirect_target & ~LO_MASK;
    win_end = in_run && !bus.stall && phase == LAST;
    go_halt = halt_pend || bus.halt;
    // a redirect arriving on the window-end clock beats any older pending one
    next_pc = take_rv ? rv_tgt : redir_pend ? tgt : pc + WIDTH'(INC);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= RESET_VECTOR;
      phase      <= '0;
      tgt        <= '0;
      redir_pend <= 1'b0;
      halt_pend  <= 1'b0;
      run_q      <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      running    <= 1'b0;
    end else begin
      run_q <= bus.run;
      done  <= win_end;
      if (take_rv) begin
        tgt        <= rv_tgt;
        redir_pend <= 1'b1;
      end
      if (take_rv && |(bus.redirect_target & LO_MASK)) err <= 1'b1;
      if (in_run && bus.halt) halt_pend <= 1'b1;
      case (state)
        IDLE: if (bus.run) begin
          state   <= RUN;
          running <= 1'b1;
          phase   <= '0;
        end
        RUN: if (win_end) begin
          pc         <= next_pc;
          phase      <= '0;
          redir_pend <= 1'b0;
          halt_pend  <= 1'b0;
          if (go_halt || !bus.run) begin
            state   <= go_halt ? HALTED : IDLE;
            running <= 1'b0;
          end
        end else if (!bus.stall) phase <= phase + 1'b1;
        HALTED: if (bus.run && !run_q) begin
          state   <= RUN;
          running <= 1'b1;
          phase   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.pc_out       = pc;
  assign bus.phase        = phase;
  assign bus.last_phase   = in_run && phase == LAST;
  assign bus.instr_done   = done;
  assign bus.running      = running;
  assign bus.misalign_err = err;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed checks of the PC sequencer with default and narrow/fast/wrapping configurations.
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;
  always #5 clk = ~clk;
  pc_sequencer_if #(.WIDTH(32), .CPI(4)) b0 ();
  pc_sequencer_if #(.WIDTH(16), .CPI(2)) b1 ();
  pc_sequencer #(.WIDTH(32), .CPI(4), .INC(4), .RESET_VECTOR(32'h0), .ALIGN_BITS(2)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(b0)
  );
  pc_sequencer #(.WIDTH(16), .CPI(2), .INC(4), .RESET_VECTOR(16'hFFF8), .ALIGN_BITS(2)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  // walk phases 1..CPI-1 of a window already sitting at phase 0, then the update edge
  task automatic run_window(input logic [31:0] exp_pc);
    for (int p = 1; p < 4; p++) begin
      tick();
      chk("phase", 32'(b0.phase), 32'(p));
      chk("done_mid", 32'(b0.instr_done), 0);
    end
    chk("last_phase", 32'(b0.last_phase), 1);
    tick();
    chk("pc_upd", b0.pc_out, exp_pc);
    chk("phase_wrap", 32'(b0.phase), 0);
    chk("done_pulse", 32'(b0.instr_done), 1);
  endtask
  initial begin
    {b0.run, b0.halt, b0.stall, b0.redirect_valid} = '0;
    b0.redirect_target = '0;
    {b1.run, b1.halt, b1.stall, b1.redirect_valid} = '0;
    b1.redirect_target = '0;
    repeat (2) tick();
    chk("rst_pc", b0.pc_out, 0);
    chk("rst_phase", 32'(b0.phase), 0);
    chk("rst_running", 32'(b0.running), 0);
    chk("rst_done", 32'(b0.instr_done), 0);
    chk("rst_err", 32'(b0.misalign_err), 0);
    chk("rst_pc_u1", 32'(b1.pc_out), 32'hFFF8);
    rst_n = 1'b1;
    // redirect while IDLE must be ignored
    b0.redirect_valid = 1'b1;
    b0.redirect_target = 32'h700;
    tick();
    b0.redirect_valid = 1'b0;
    chk("idle_running", 32'(b0.running), 0);
    b0.run = 1'b1;
    tick();
    chk("run_enter", 32'(b0.running), 1);
    chk("run_phase0", 32'(b0.phase), 0);
    chk("run_pc0", b0.pc_out, 0);
    run_window(32'h4);
    run_window(32'h8);
    // single redirect at phase 1
    tick();
    b0.redirect_valid = 1'b1;
    b0.redirect_target = 32'h100;
    tick();
    b0.redirect_valid = 1'b0;
    tick();
    chk("pre_redir_pc", b0.pc_out, 32'h8);
    tick();
    chk("redir_pc", b0.pc_out, 32'h100);
    run_window(32'h104);
    // two redirects in one window: last wins
    b0.redirect_valid = 1'b1;
    b0.redirect_target = 32'h200;
    tick();
    b0.redirect_valid = 1'b0;
    tick();
    b0.redirect_valid = 1'b1;
    b0.redirect_target = 32'h300;
    tick();
    b0.redirect_valid = 1'b0;
    tick();
    chk("redir_last_wins", b0.pc_out, 32'h300);
    // stall at phase 3 stretches the window to 7 clocks
    repeat (3) tick();
    b0.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_phase", 32'(b0.phase), 3);
      chk("stall_pc", b0.pc_out, 32'h300);
      chk("stall_done", 32'(b0.instr_done), 0);
    end
    b0.stall = 1'b0;
    tick();
    chk("stall_pc_upd", b0.pc_out, 32'h304);
    chk("stall_done_upd", 32'(b0.instr_done), 1);
    // misaligned redirect is aligned down and flagged
    b0.redirect_valid = 1'b1;
    b0.redirect_target = 32'h106;
    tick();
    b0.redirect_valid = 1'b0;
    chk("misalign_set", 32'(b0.misalign_err), 1);
    repeat (3) tick();
    chk("misalign_pc", b0.pc_out, 32'h104);
    b0.redirect_valid = 1'b1;
    b0.redirect_target = 32'h400;
    tick();
    b0.redirect_valid = 1'b0;
    repeat (3) tick();
    chk("aligned_pc", b0.pc_out, 32'h400);
    chk("misalign_sticky", 32'(b0.misalign_err), 1);
    // redirect on the window-end clock applies at that edge
    repeat (3) tick();
    b0.redirect_valid = 1'b1;
    b0.redirect_target = 32'h500;
    tick();
    b0.redirect_valid = 1'b0;
    chk("edge_redir_pc", b0.pc_out, 32'h500);
    // halt at phase 1: window completes, then frozen
    tick();
    b0.halt = 1'b1;
    tick();
    b0.halt = 1'b0;
    tick();
    chk("halt_still_run", 32'(b0.running), 1);
    tick();
    chk("halt_pc_upd", b0.pc_out, 32'h504);
    chk("halt_running", 32'(b0.running), 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("halted_pc", b0.pc_out, 32'h504);
      chk("halted_done", 32'(b0.instr_done), 0);
    end
    chk("halted_phase", 32'(b0.phase), 0);
    b0.run = 1'b0;
    tick();
    b0.run = 1'b1;
    tick();
    chk("resume_running", 32'(b0.running), 1);
    chk("resume_phase", 32'(b0.phase), 0);
    repeat (2) tick();
    chk("pre_rst_phase", 32'(b0.phase), 2);
    // async reset mid-window
    rst_n = 1'b0;
    #1;
    chk("async_pc", b0.pc_out, 0);
    chk("async_running", 32'(b0.running), 0);
    chk("async_phase", 32'(b0.phase), 0);
    chk("async_err", 32'(b0.misalign_err), 0);
    b0.run = 1'b0;
    tick();
    rst_n = 1'b1;
    // run dropped mid-window: finish window then IDLE
    b0.run = 1'b1;
    tick();
    b0.run = 1'b0;
    run_window(32'h4);
    chk("idle_after_run0", 32'(b0.running), 0);
    tick();
    chk("idle_hold_pc", b0.pc_out, 32'h4);
    chk("idle_no_done", 32'(b0.instr_done), 0);
    // narrow, CPI=2, wrapping instance
    b1.run = 1'b1;
    tick();
    chk("u1_pc0", 32'(b1.pc_out), 32'hFFF8);
    chk("u1_phase0", 32'(b1.phase), 0);
    tick();
    chk("u1_last", 32'(b1.last_phase), 1);
    tick();
    chk("u1_pc1", 32'(b1.pc_out), 32'hFFFC);
    chk("u1_done", 32'(b1.instr_done), 1);
    repeat (2) tick();
    chk("u1_wrap", 32'(b1.pc_out), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised multi-cycle program counter for the soft-core MIPS datapath; successor to the fixed 4-cycle, load-only counter.
- Holds the current instruction address and advances it once per instruction window of CPI clocks, either by sequential increment or by a latched branch/jump redirect.
- Adds reset vector, run/halt control, stall, phase outputs and misalignment detection.
- Feeds instruction memory address and the phase signals consumed by the multi-cycle control unit.

Parameters:
- WIDTH, 32, address width in bits (>= 8).
- CPI, 4, clocks per instruction window (2..16).
- INC, 4, sequential increment added at window end.
- RESET_VECTOR, 0, pc_out value after reset.
- ALIGN_BITS, 2, low address bits that must be zero in a redirect target.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- run, input, 1, level; start or continue sequencing.
- halt, input, 1, pulse; stop at the end of the current window.
- stall, input, 1, level; freezes phase counter and PC.
- redirect_valid, input, 1, pulse; request a branch/jump.
- redirect_target, input, WIDTH, branch/jump address (the old data_in).
- pc_out, output, WIDTH, current instruction address (registered).
- phase, output, clog2(CPI), current phase 0..CPI-1.
- last_phase, output, 1, high when phase == CPI-1 in RUN.
- instr_done, output, 1, one-clock pulse on the clock after pc_out updates.
- running, output, 1, high in RUN.
- misalign_err, output, 1, sticky; set on a misaligned redirect.

Behaviour:
- Reset (rst_n low, async):
  - pc_out = RESET_VECTOR, phase = 0, state = IDLE.
  - pending redirect cleared; instr_done, misalign_err and running all 0.
  - Reset asserted mid-window aborts the window immediately; the PC does not update.
- FSM states:
  - IDLE: phase held at 0. run=1 -> RUN on the next clock.
  - RUN: phase increments each clock unless stall=1.
    - At phase==CPI-1 with stall=0: phase wraps to 0 and pc_out updates.
    - If halt was seen during the window (latched halt_pend), go to HALTED at the same edge.
    - If run=0 at the window end, go to IDLE.
  - HALTED: everything frozen. Leaves only via reset or run rising 0->1, which goes to RUN with phase 0.
- PC update at window end:
  - pending redirect present -> pc_out = target.
  - otherwise pc_out = pc_out + INC, modulo 2^WIDTH (wraps silently, e.g. 0xFFFFFFFC -> 0x00000000).
  - The pending redirect clears on that update.
- Redirect latching:
  - redirect_valid is accepted only in RUN; ignored in IDLE and HALTED.
  - Accepted in any phase, including under stall.
  - Several in one window: the last one wins.
  - A redirect in the same clock as the window-end edge applies at that edge, not the next window.
- Misalignment:
  - If target[ALIGN_BITS-1:0] != 0: misalign_err is set (sticky until reset).
  - The target is used with its low ALIGN_BITS forced to zero.
- stall:
  - Suppresses the phase advance and the PC update, including at CPI-1; the window simply lengthens.
  - Does not block redirect or halt latching.
- halt and stall together: halt is latched and takes effect at the first non-stalled window end.
- instr_done:
  - Asserted for exactly one clock after each PC update.
  - Never asserted in IDLE, HALTED, or after reset.
- Latency:
  - First update occurs CPI clocks after entering RUN.
  - Windows are exactly CPI clocks apart with no stall.

Test Plan:
- Reset, then run=1 held, CPI=4, INC=4 -> pc_out 0,4,8,12 with updates every 4 clocks; instr_done pulses 4 clocks apart; phase cycles 0..3.
- Redirect 0x00000100 at phase 1 of the window with pc=8 -> next pc 0x100 (not 12), then 0x104 one window later; two redirects (0x200 at phase 0, 0x300 at phase 2) -> 0x300.
- stall=1 for 3 clocks at phase 3 -> window lasts 7 clocks; pc increments once; no instr_done during stall.
- Redirect 0x00000106 -> pc becomes 0x104; misalign_err=1 and remains 1 after later aligned redirects until rst_n low.
- halt pulse at phase 1 -> PC still updates at window end, then HALTED with pc frozen for 10 clocks; run toggled 0->1 -> resumes at phase 0; rst_n pulsed low at phase 2 -> pc_out immediately equals RESET_VECTOR, state IDLE.
- RESET_VECTOR=0xFFFFFFF8 -> pc 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000 (wrap); repeat with CPI=2, WIDTH=16 -> updates every 2 clocks.
